// File: rtl/euler_ctrl_pkg.sv
// Shared definitions for the Euler step sequencer: state encodings and
// default widths for the step counter and the per-step watchdog.
package euler_ctrl_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_TO_W  = 12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        FIN  = ST_FIN
    } state_e;

endpackage

// File: rtl/euler_wdog_cnt.sv
// Per-step watchdog: TO_W-bit counter with synchronous clear and enable.
// Ports: clk (falling edge), rst_async, clr, en in; expire out (cnt == TIMEOUT).
module euler_wdog_cnt
    import euler_ctrl_pkg::*;
#(
    parameter int TO_W    = DEF_TO_W,
    parameter int TIMEOUT = 4095
) (
    input  logic clk,
    input  logic rst_async,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(negedge clk or posedge rst_async) begin
        if (rst_async) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero limit disables the watchdog entirely.
    assign expire = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT));

endmodule

// File: rtl/euler_step_sequencer.sv
// Runs an N-step Euler integration loop: one step_start pulse per step,
// waits for step_done, with watchdog, abort and step index tracking.
// Ports: clk, rst_async, rst_sync, start_req, step_count, step_done, abort in;
//        step_start, step_idx, busy, done, timeout_err out (all registered).
module euler_step_sequencer
    import euler_ctrl_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TO_W    = DEF_TO_W,
    parameter int TIMEOUT = 4095
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic             rst_sync,
    input  logic             start_req,
    input  logic [CNT_W-1:0] step_count,
    input  logic             step_done,
    input  logic             abort,
    output logic             step_start,
    output logic [CNT_W-1:0] step_idx,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    state_e           state_q, state_d;
    logic             step_start_q, step_start_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;

    logic wd_clr;
    logic wd_en;
    logic wd_expire;
    logic last_step;

    // One extra bit so idx+1 never wraps back onto a small target.
    assign last_step = ({1'b0, idx_q} + (CNT_W+1)'(1)) == {1'b0, target_q};

    always_comb begin
        state_d      = state_q;
        step_start_d = 1'b0;
        idx_d        = idx_q;
        target_d     = target_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        tmo_d        = tmo_q;
        if (rst_sync) begin
            state_d  = IDLE;
            idx_d    = '0;
            target_d = '0;
            busy_d   = 1'b0;
            tmo_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_req) begin
                        tmo_d = 1'b0;
                        if (step_count != '0) begin
                            target_d     = step_count;
                            idx_d        = '0;
                            step_start_d = 1'b1;
                            busy_d       = 1'b1;
                            state_d      = WAIT;
                        end else begin
                            done_d  = 1'b1;
                            state_d = FIN;
                        end
                    end
                end
                WAIT: begin
                    // A step cannot finish on its own launch cycle.
                    if (abort) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (step_done && !step_start_q) begin
                        if (last_step) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = FIN;
                        end else begin
                            idx_d        = idx_q + CNT_W'(1);
                            step_start_d = 1'b1;
                        end
                    end else if (wd_expire) begin
                        tmo_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                FIN: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Counter restarts with every launch and only runs between launches.
    assign wd_clr = rst_sync || (state_q != WAIT) || step_start_d;
    assign wd_en  = (state_q == WAIT) && !step_start_q;

    euler_wdog_cnt #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst_async (rst_async),
        .clr       (wd_clr),
        .en        (wd_en),
        .expire    (wd_expire)
    );

    always_ff @(negedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q      <= IDLE;
            step_start_q <= 1'b0;
            idx_q        <= '0;
            target_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_start_q <= step_start_d;
            idx_q        <= idx_d;
            target_q     <= target_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tmo_q        <= tmo_d;
        end
    end

    assign step_start  = step_start_q;
    assign step_idx    = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = tmo_q;

endmodule
